// File: rtl/or4_stim_checker_pkg.sv
// rtl/or4_stim_checker_pkg.sv - shared types, constants and golden OR function for the OR4 stimulus checker.
package or4_stim_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int              VEC_BITS = 4;
  localparam logic [3:0]      VEC_LAST = 4'd15;
  localparam int              ERR_W    = 5;
  localparam logic [ERR_W-1:0] ERR_MAX = 5'd16;

  // Response of a healthy OR stage: {e, f, g} = {a|b, c|d, a|b|c|d}, a = vec[3].
  function automatic logic [2:0] or4_expect(input logic [VEC_BITS-1:0] vec);
    return {vec[3] | vec[2], vec[1] | vec[0], |vec};
  endfunction

endpackage

// File: rtl/or4_stim_checker_if.sv
// rtl/or4_stim_checker_if.sv - stimulus, response and status bundle between the checker and the OR stage/host.
interface or4_stim_checker_if;
  import or4_stim_checker_pkg::*;

  logic             start;
  logic             a, b, c, d;
  logic             e, f, g;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       first_err;

  modport master (
    input  start, e, f, g,
    output a, b, c, d, busy, done, pass, err_count, first_err
  );

  modport slave (
    output start, e, f, g,
    input  a, b, c, d, busy, done, pass, err_count, first_err
  );

endinterface

// File: rtl/or4_golden_model.sv
// rtl/or4_golden_model.sv - combinational expected {e,f,g} for a 4-bit OR stage vector.
module or4_golden_model
  import or4_stim_checker_pkg::*;
(
  input  logic [VEC_BITS-1:0] vec,
  output logic [2:0]          exp_efg
);

  assign exp_efg = or4_expect(vec);

endmodule

// File: rtl/or4_stim_checker.sv
// rtl/or4_stim_checker.sv - clocked 16-vector sweep of an OR stage with error count and first failing vector.
module or4_stim_checker
  import or4_stim_checker_pkg::*;
#(
  parameter int DWELL = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  or4_stim_checker_if.master   bus
);

  localparam int               CNT_W      = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t              state_q, state_d;
  logic [VEC_BITS-1:0] vec_q, vec_d;
  logic [CNT_W-1:0]    dwell_q, dwell_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [3:0]          first_q, first_d;
  logic                start_q, start_d;

  logic [2:0]          exp_efg;
  logic                start_rise;
  logic                mismatch;

  or4_golden_model u_golden (
    .vec     (vec_q),
    .exp_efg (exp_efg)
  );

  assign start_d    = bus.start;
  assign start_rise = bus.start & ~start_q;
  assign mismatch   = ({bus.e, bus.f, bus.g} != exp_efg);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    dwell_d = dwell_q;
    err_d   = err_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_rise) begin
          state_d = ST_RUN;
          vec_d   = '0;
          dwell_d = '0;
          err_d   = '0;
          first_d = '0;
        end
      end
      ST_RUN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (mismatch) begin
            if (err_q == '0) first_d = vec_q;
            if (err_q != ERR_MAX) err_d = err_q + 5'd1;
          end
          if (vec_q == VEC_LAST) state_d = ST_DONE;
          else                   vec_d   = vec_q + 4'd1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      // Encoding 2'd3 is unreachable; fall back to IDLE if it ever appears.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      dwell_q <= '0;
      err_q   <= '0;
      first_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
      first_q <= first_d;
      start_q <= start_d;
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d} = vec_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = (state_q == ST_DONE) && (err_q == '0);
  assign bus.err_count = err_q;
  assign bus.first_err = first_q;

endmodule

// File: tb/tb_or4_stim_checker.sv
// tb/tb_or4_stim_checker.sv - directed self-checking bench for or4_stim_checker with an inline OR stage.
module tb_or4_stim_checker;

  typedef struct {
    logic [4:0] err;
    logic [3:0] first;
    logic       pass;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic fault_g;
  int   tests = 0;
  int   fails = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  or4_stim_checker_if bus1 ();
  or4_stim_checker_if bus2 ();

  or4_stim_checker #(.DWELL(10)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  or4_stim_checker #(.DWELL(1))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [3:0] v1, v2;
  assign v1 = {bus1.a, bus1.b, bus1.c, bus1.d};
  assign v2 = {bus2.a, bus2.b, bus2.c, bus2.d};

  // OR stage for dut1; fault_g pulls g low at vectors 5 and 9.
  assign bus1.e = bus1.a | bus1.b;
  assign bus1.f = bus1.c | bus1.d;
  assign bus1.g = (fault_g && (v1 == 4'd5 || v1 == 4'd9)) ? 1'b0 : |v1;

  // OR stage for dut2 with g stuck high: only the all-zero vector disagrees.
  assign bus2.e = bus2.a | bus2.b;
  assign bus2.f = bus2.c | bus2.d;
  assign bus2.g = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [4:0] err, input logic [3:0] first,
                            input logic pass);
    res_t r;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    r = sb.pop_front();
    chk({tag, "_err_count"}, 32'(err), 32'(r.err));
    chk({tag, "_first_err"}, 32'(first), 32'(r.first));
    chk({tag, "_pass"}, 32'(pass), 32'(r.pass));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_abcd"}, 32'(v1), 32'd0);
    chk({tag, "_busy"}, 32'(bus1.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus1.done), 32'd0);
    chk({tag, "_pass"}, 32'(bus1.pass), 32'd0);
    chk({tag, "_err"}, 32'(bus1.err_count), 32'd0);
    chk({tag, "_first"}, 32'(bus1.first_err), 32'd0);
  endtask

  // hold: edges for which start stays high; pulse7: re-pulse start when vector 7 appears.
  task automatic run_sweep(input string tag, input int hold, input bit pulse7,
                           input logic [4:0] e_err, input logic [3:0] e_first);
    res_t       r;
    int         n;
    int         hold_cnt;
    int         exp_v;
    logic [3:0] cur;
    bit         seen;
    bit         got_done;
    r.err   = e_err;
    r.first = e_first;
    r.pass  = (e_err == 5'd0);
    sb.push_back(r);
    n = 0; hold_cnt = 0; exp_v = 0; cur = 4'd0; seen = 1'b0; got_done = 1'b0;
    @(negedge clk);
    bus1.start = 1'b1;
    while (n < 400 && !got_done) begin
      @(posedge clk);
      #1;
      n++;
      if (n >= hold) bus1.start = 1'b0;
      if (n == 1) begin
        chk({tag, "_enter_busy"}, 32'(bus1.busy), 32'd1);
        chk({tag, "_enter_err"}, 32'(bus1.err_count), 32'd0);
        chk({tag, "_enter_first"}, 32'(bus1.first_err), 32'd0);
      end
      if (bus1.done) begin
        got_done = 1'b1;
      end else if (bus1.busy) begin
        if (!seen || v1 != cur) begin
          if (seen) chk({tag, "_hold_len"}, 32'(hold_cnt), 32'd10);
          chk({tag, "_vec_order"}, 32'(v1), 32'(exp_v));
          exp_v++;
          cur      = v1;
          seen     = 1'b1;
          hold_cnt = 1;
          if (pulse7 && v1 == 4'd7) bus1.start = 1'b1;
        end else begin
          hold_cnt++;
        end
      end
    end
    chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
    chk({tag, "_done_cycle"}, 32'(n), 32'd161);
    chk({tag, "_vec_count"}, 32'(exp_v), 32'd16);
    chk({tag, "_last_hold"}, 32'(hold_cnt), 32'd10);
    chk({tag, "_abcd_hold"}, 32'(v1), 32'd15);
    chk({tag, "_busy_low"}, 32'(bus1.busy), 32'd0);
    chk_result(tag, bus1.err_count, bus1.first_err, bus1.pass);
  endtask

  initial begin
    int  n;
    bit  reached;
    rst_n      = 1'b0;
    fault_g    = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_dut2_done", 32'(bus2.done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(bus1.busy), 32'd0);

    run_sweep("clean", 1, 1'b0, 5'd0, 4'd0);

    fault_g = 1'b1;
    run_sweep("fault", 1, 1'b0, 5'd2, 4'd5);
    fault_g = 1'b0;

    run_sweep("start_in_run", 1, 1'b1, 5'd0, 4'd0);

    // Abort a sweep with reset once vector 10 is on the outputs.
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      if (v1 == 4'd10) reached = 1'b1;
    end
    chk("abort_reached_vec10", 32'(reached), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_done", 32'(bus1.done), 32'd0);
    run_sweep("after_abort", 1, 1'b0, 5'd0, 4'd0);

    fault_g = 1'b1;
    run_sweep("long_start", 50, 1'b0, 5'd2, 4'd5);
    fault_g = 1'b0;
    repeat (5) @(negedge clk);
    chk("long_start_stays_done", 32'(bus1.done), 32'd1);
    chk("long_start_err_kept", 32'(bus1.err_count), 32'd2);
    run_sweep("second_pulse", 1, 1'b0, 5'd0, 4'd0);

    // DWELL=1 instance: one cycle per vector.
    begin
      res_t r;
      r.err = 5'd1; r.first = 4'd0; r.pass = 1'b0;
      sb.push_back(r);
    end
    n = 0;
    @(negedge clk);
    bus2.start = 1'b1;
    while (n < 60 && !bus2.done) begin
      @(posedge clk);
      #1;
      n++;
      bus2.start = 1'b0;
      if (n == 1) chk("dwell1_first_vec", 32'(v2), 32'd0);
    end
    chk("dwell1_done", 32'(bus2.done), 32'd1);
    chk("dwell1_done_cycle", 32'(n), 32'd17);
    chk("dwell1_abcd_hold", 32'(v2), 32'd15);
    chk_result("dwell1", bus2.err_count, bus2.first_err, bus2.pass);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
